time_mode_engine: RTL and testbench

//  Parametrised multi-mode timekeeping core: wall clock (12h/24h view), countdown timer, stopwatch.

---
 rtl/time_mode_pkg.sv | 20 ++
 rtl/time_counter.sv | 55 +++++
 rtl/time_mode_engine.sv | 149 ++++++++++++++
 tb/tb_time_mode_engine.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/time_mode_pkg.sv
// time_mode_pkg: mode/state encodings, time field limits and helpers shared by time_mode_engine
// No ports; imported by time_counter and time_mode_engine.
package time_mode_pkg;
  localparam logic [1:0] MODE_CLK12 = 2'b00;
  localparam logic [1:0] MODE_CLK24 = 2'b01;
  localparam logic [1:0] MODE_TIMER = 2'b10;
  localparam logic [1:0] MODE_SW    = 2'b11;
  localparam logic [9:0] MS_MAX     = 10'd999;
  localparam logic [5:0] SEC_MAX    = 6'd59;
  localparam logic [5:0] MIN_MAX    = 6'd59;
  localparam logic [5:0] HR24_MAX   = 6'd23;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_PAUSE = 2'd2, ST_EXPIRED = 2'd3} state_e;
  function automatic logic [5:0] clamp6(input logic [5:0] v, input logic [5:0] lim);
    return v > lim ? lim : v;
  endfunction
  // One wrapping step of a single field in either direction.
  function automatic logic [9:0] step(input logic [9:0] v, input logic [9:0] max, input logic up);
    return up ? (v == max ? 10'd0 : v + 10'd1) : (v == 10'd0 ? max : v - 10'd1);
  endfunction
endpackage

// File: rtl/time_counter.sv
// time_counter: hh:mm:ss.mmm binary counter with load, enable, up/down and hour limit
// Ports: clk_i, reset_i (async, active-high); load_i loads ld_*_i with ms=0 (wins over en_i);
//   en_i advances one ms in the up_i direction; hrs_o/min_o/sec_o/ms_o current value;
//   is_zero_o all fields 0; is_max_o value is HR_MAX:59:59.999.
module time_counter
  import time_mode_pkg::*;
#(
  parameter logic [5:0] HR_MAX = HR24_MAX
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       load_i,
  input  logic       en_i,
  input  logic       up_i,
  input  logic [5:0] ld_hrs_i,
  input  logic [5:0] ld_min_i,
  input  logic [5:0] ld_sec_i,
  output logic [5:0] hrs_o,
  output logic [5:0] min_o,
  output logic [5:0] sec_o,
  output logic [9:0] ms_o,
  output logic       is_zero_o,
  output logic       is_max_o
);
  logic [5:0] hrs_q, min_q, sec_q;
  logic [9:0] ms_q;
  logic ms_c, sec_c, min_c;
  // Carry (up) or borrow (down) ripples when every lower field sits at its wrap point.
  assign ms_c  = ms_q == (up_i ? MS_MAX : 10'd0);
  assign sec_c = ms_c && sec_q == (up_i ? SEC_MAX : 6'd0);
  assign min_c = sec_c && min_q == (up_i ? MIN_MAX : 6'd0);
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      hrs_q <= '0;
      min_q <= '0;
      sec_q <= '0;
      ms_q  <= '0;
    end else if (load_i) begin
      hrs_q <= ld_hrs_i;
      min_q <= ld_min_i;
      sec_q <= ld_sec_i;
      ms_q  <= '0;
    end else if (en_i) begin
      ms_q <= step(ms_q, MS_MAX, up_i);
      if (ms_c) sec_q <= 6'(step(10'(sec_q), 10'(SEC_MAX), up_i));
      if (sec_c) min_q <= 6'(step(10'(min_q), 10'(MIN_MAX), up_i));
      if (min_c) hrs_q <= 6'(step(10'(hrs_q), 10'(HR_MAX), up_i));
    end
  assign hrs_o     = hrs_q;
  assign min_o     = min_q;
  assign sec_o     = sec_q;
  assign ms_o      = ms_q;
  assign is_zero_o = {hrs_q, min_q, sec_q, ms_q} == '0;
  assign is_max_o  = hrs_q == HR_MAX && min_q == MIN_MAX && sec_q == SEC_MAX && ms_q == MS_MAX;
endmodule

// File: rtl/time_mode_engine.sv
// time_mode_engine: wall clock (12h/24h view), countdown timer and stopwatch with ms prescaler and debounced buttons
// Ports: clk_i, reset_i (async, active-high); mode_i 00 clk12 / 01 clk24 / 10 timer / 11 stopwatch;
//   start_stop_i, clear_i raw async buttons; set_en_i level load of set_*_i into the wall clock;
//   hrs_o/min_o/sec_o/ms_o/pm_o registered display tuple; running_o, expired_o status; ms_tick_o ms pulse.
module time_mode_engine
  import time_mode_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int DEBOUNCE_MS = 10,
  parameter int SW_HR_MAX   = 99
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] mode_i,
  input  logic       start_stop_i,
  input  logic       clear_i,
  input  logic       set_en_i,
  input  logic [5:0] set_hrs_i,
  input  logic [5:0] set_min_i,
  input  logic [5:0] set_sec_i,
  output logic [5:0] hrs_o,
  output logic [5:0] min_o,
  output logic [5:0] sec_o,
  output logic [9:0] ms_o,
  output logic       pm_o,
  output logic       running_o,
  output logic       expired_o,
  output logic       ms_tick_o
);
  localparam logic [31:0] TPM_LAST = 32'(CLK_HZ / 1000 - 1);
  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_MS > 0 ? DEBOUNCE_MS - 1 : 0);
  // hrs_o is 6 bits wide, so the stopwatch ceiling cannot exceed 63 hours.
  localparam logic [5:0] SW_HR_LIM = 6'(SW_HR_MAX > 63 ? 63 : SW_HR_MAX);
  logic [31:0] presc_q;
  logic tick;
  logic [1:0] s1_q, s2_q, db_q, prev_q;
  logic [15:0] cnt_q [2];
  logic p_start, p_clear, is_tm, is_sw, is_12, st_tm, cl_tm, st_sw, cl_sw;
  logic [5:0] pre_h, pre_m, pre_s, h12, hrs_d, min_d, sec_d;
  logic [5:0] wall_h, wall_m, wall_s, tm_h, tm_m, tm_s, sw_h, sw_m, sw_s;
  logic [9:0] wall_ms, tm_ms, sw_ms, ms_d;
  logic tm_zero, tm_one, sw_max, pm_d, running_d;
  logic wall_zero_unused, wall_max_unused, tm_max_unused, sw_zero_unused;
  state_e tm_q, sw_q;
  assign tick = presc_q == TPM_LAST;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      presc_q <= '0;
      ms_tick_o <= 1'b0;
    end else begin
      presc_q <= tick ? '0 : presc_q + 32'd1;
      ms_tick_o <= tick;
    end
  // Bit 0 = start/stop, bit 1 = clear. A changed synced level is accepted after DB_LAST+1 ticks.
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      s1_q <= '0;
      s2_q <= '0;
      db_q <= '0;
      prev_q <= '0;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      s1_q <= {clear_i, start_stop_i};
      s2_q <= s1_q;
      prev_q <= db_q;
      for (int i = 0; i < 2; i++)
        if (s2_q[i] == db_q[i]) cnt_q[i] <= '0;
        else if (DEBOUNCE_MS == 0 || (tick && cnt_q[i] == DB_LAST)) begin
          db_q[i] <= s2_q[i];
          cnt_q[i] <= '0;
        end else if (tick) cnt_q[i] <= cnt_q[i] + 16'd1;
    end
  assign p_start = db_q[0] & ~prev_q[0];
  assign p_clear = db_q[1] & ~prev_q[1];
  assign is_tm = mode_i == MODE_TIMER;
  assign is_sw = mode_i == MODE_SW;
  assign is_12 = mode_i == MODE_CLK12;
  // Clear beats start; a stopwatch clear while running is dropped entirely.
  assign cl_tm = p_clear & is_tm;
  assign st_tm = p_start & ~p_clear & is_tm;
  assign cl_sw = p_clear & is_sw & (sw_q != ST_RUN);
  assign st_sw = p_start & ~p_clear & is_sw;
  assign pre_h = clamp6(set_hrs_i, HR24_MAX);
  assign pre_m = clamp6(set_min_i, MIN_MAX);
  assign pre_s = clamp6(set_sec_i, SEC_MAX);
  assign tm_one = {tm_h, tm_m, tm_s} == '0 && tm_ms == 10'd1;
  time_counter #(.HR_MAX(HR24_MAX)) u_wall (
    .clk_i(clk_i), .reset_i(reset_i), .load_i(set_en_i), .en_i(tick & ~set_en_i), .up_i(1'b1),
    .ld_hrs_i(pre_h), .ld_min_i(pre_m), .ld_sec_i(pre_s),
    .hrs_o(wall_h), .min_o(wall_m), .sec_o(wall_s), .ms_o(wall_ms),
    .is_zero_o(wall_zero_unused), .is_max_o(wall_max_unused)
  );
  time_counter #(.HR_MAX(HR24_MAX)) u_timer (
    .clk_i(clk_i), .reset_i(reset_i), .load_i(cl_tm), .en_i(tick && tm_q == ST_RUN && !tm_zero), .up_i(1'b0),
    .ld_hrs_i(pre_h), .ld_min_i(pre_m), .ld_sec_i(pre_s),
    .hrs_o(tm_h), .min_o(tm_m), .sec_o(tm_s), .ms_o(tm_ms),
    .is_zero_o(tm_zero), .is_max_o(tm_max_unused)
  );
  time_counter #(.HR_MAX(SW_HR_LIM)) u_sw (
    .clk_i(clk_i), .reset_i(reset_i), .load_i(cl_sw), .en_i(tick && sw_q == ST_RUN && !sw_max), .up_i(1'b1),
    .ld_hrs_i(6'd0), .ld_min_i(6'd0), .ld_sec_i(6'd0),
    .hrs_o(sw_h), .min_o(sw_m), .sec_o(sw_s), .ms_o(sw_ms),
    .is_zero_o(sw_zero_unused), .is_max_o(sw_max)
  );
  // Expiry is taken on the same tick that steps 0.001 -> 0, ahead of any start press.
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) tm_q <= ST_IDLE;
    else if (cl_tm) tm_q <= ST_IDLE;
    else
      case (tm_q)
        ST_IDLE: if (st_tm && !tm_zero) tm_q <= ST_RUN;
        ST_RUN: if (tick && tm_one) tm_q <= ST_EXPIRED; else if (st_tm) tm_q <= ST_PAUSE;
        ST_PAUSE: if (st_tm) tm_q <= ST_RUN;
        default: ;
      endcase
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) sw_q <= ST_IDLE;
    else if (cl_sw) sw_q <= ST_IDLE;
    else
      case (sw_q)
        ST_RUN: if (sw_max || st_sw) sw_q <= ST_PAUSE;
        default: if (st_sw) sw_q <= ST_RUN;
      endcase
  assign h12 = wall_h == 6'd0 ? 6'd12 : wall_h > 6'd12 ? wall_h - 6'd12 : wall_h;
  assign hrs_d = is_tm ? tm_h : is_sw ? sw_h : is_12 ? h12 : wall_h;
  assign min_d = is_tm ? tm_m : is_sw ? sw_m : wall_m;
  assign sec_d = is_tm ? tm_s : is_sw ? sw_s : wall_s;
  assign ms_d = is_tm ? tm_ms : is_sw ? sw_ms : wall_ms;
  assign pm_d = is_12 && wall_h >= 6'd12;
  assign running_d = (is_tm && tm_q == ST_RUN) || (is_sw && sw_q == ST_RUN);
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      hrs_o <= '0;
      min_o <= '0;
      sec_o <= '0;
      ms_o <= '0;
      pm_o <= 1'b0;
      running_o <= 1'b0;
      expired_o <= 1'b0;
    end else begin
      hrs_o <= hrs_d;
      min_o <= min_d;
      sec_o <= sec_d;
      ms_o <= ms_d;
      pm_o <= pm_d;
      running_o <= running_d;
      expired_o <= tm_q == ST_EXPIRED;
    end
endmodule

// File: tb/tb_time_mode_engine.sv
// tb_time_mode_engine: scoreboard bench for time_mode_engine at 10 clk/ms, no debounce delay
module tb_time_mode_engine;
  logic clk_i = 1'b0;
  logic reset_i, start_stop_i, clear_i, set_en_i;
  logic [1:0] mode_i;
  logic [5:0] set_hrs_i, set_min_i, set_sec_i, hrs_o, min_o, sec_o;
  logic [9:0] ms_o;
  logic pm_o, running_o, expired_o, ms_tick_o;
  logic [30:0] obs, ev;
  logic [30:0] sb[$];
  int total = 0;
  int bad = 0;

  time_mode_engine #(.CLK_HZ(10_000), .DEBOUNCE_MS(0), .SW_HR_MAX(99)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .mode_i(mode_i), .start_stop_i(start_stop_i), .clear_i(clear_i),
    .set_en_i(set_en_i), .set_hrs_i(set_hrs_i), .set_min_i(set_min_i), .set_sec_i(set_sec_i),
    .hrs_o(hrs_o), .min_o(min_o), .sec_o(sec_o), .ms_o(ms_o), .pm_o(pm_o),
    .running_o(running_o), .expired_o(expired_o), .ms_tick_o(ms_tick_o)
  );

  always #5 clk_i = ~clk_i;
  assign obs = {hrs_o, min_o, sec_o, ms_o, pm_o, running_o, expired_o};

  function automatic logic [30:0] tup(int h, int m, int s, int ms, int pm, int run, int ex);
    return {6'(h), 6'(m), 6'(s), 10'(ms), 1'(pm), 1'(run), 1'(ex)};
  endfunction

  function automatic string fmt(logic [30:0] v);
    return $sformatf("%0d:%0d:%0d.%0d pm=%0d run=%0d exp=%0d", v[30:25], v[24:19], v[18:13], v[12:3], v[2], v[1], v[0]);
  endfunction

  task automatic wait_ms(int n);
    for (int k = 0; k < n; k++) begin
      int c = 0;
      do begin @(negedge clk_i); c++; end while (!ms_tick_o && c < 40);
      if (!ms_tick_o) begin
        total++; bad++;
        $display("FAIL tick_timeout: ms_tick_o=%0d after 40 cycles, need 1", ms_tick_o);
        return;
      end
    end
  endtask

  task automatic press(logic s, logic c);
    start_stop_i = s; clear_i = c;
    repeat (3) @(negedge clk_i);
    start_stop_i = 1'b0; clear_i = 1'b0;
    repeat (3) @(negedge clk_i);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_i);
    sb.push_back(tup(0, 0, 0, 0, 0, 0, 0));
    ev = sb.pop_front(); total++;
    if (obs !== ev) begin bad++; $display("FAIL reset_outputs: got %s want %s", fmt(obs), fmt(ev)); end
    total++;
    if (ms_tick_o !== 1'b0) begin bad++; $display("FAIL reset_tick: got %0d want 0", ms_tick_o); end
    reset_i = 1'b0;
  endtask

  task automatic test_tick();
    int c = 0;
    do begin @(negedge clk_i); c++; end while (!ms_tick_o && c < 40);
    c = 0;
    do begin @(negedge clk_i); c++; end while (!ms_tick_o && c < 40);
    total++;
    if (c !== 10) begin bad++; $display("FAIL tick_period: got %0d cycles want 10", c); end
    @(negedge clk_i);
    total++;
    if (ms_tick_o !== 1'b0) begin bad++; $display("FAIL tick_width: got %0d want 0", ms_tick_o); end
  endtask

  task automatic test_wall_rollover();
    mode_i = 2'b01; set_hrs_i = 6'd23; set_min_i = 6'd59; set_sec_i = 6'd59; set_en_i = 1'b1;
    sb.push_back(tup(23, 59, 59, 0, 0, 0, 0));
    repeat (3) @(negedge clk_i);
    ev = sb.pop_front(); total++;
    if (obs !== ev) begin bad++; $display("FAIL wall_load: got %s want %s", fmt(obs), fmt(ev)); end
    set_en_i = 1'b0;
    sb.push_back(tup(0, 0, 0, 0, 0, 0, 0));
    wait_ms(1000);
    @(negedge clk_i);
    ev = sb.pop_front(); total++;
    if (obs !== ev) begin bad++; $display("FAIL wall_rollover: got %s want %s", fmt(obs), fmt(ev)); end
    mode_i = 2'b00;
    sb.push_back(tup(12, 0, 0, 0, 0, 0, 0));
    @(negedge clk_i);
    ev = sb.pop_front(); total++;
    if (obs !== ev) begin bad++; $display("FAIL clk12_midnight: got %s want %s", fmt(obs), fmt(ev)); end
  endtask

  task automatic test_wall_set();
    set_hrs_i = 6'd13; set_min_i = 6'd5; set_sec_i = 6'd0; set_en_i = 1'b1;
    sb.push_back(tup(1, 5, 0, 0, 1, 0, 0));
    repeat (3) @(negedge clk_i);
    ev = sb.pop_front(); total++;
    if (obs !== ev) begin bad++; $display("FAIL clk12_pm: got %s want %s", fmt(obs), fmt(ev)); end
    mode_i = 2'b01; set_hrs_i = 6'd30;
    sb.push_back(tup(23, 5, 0, 0, 0, 0, 0));
    repeat (3) @(negedge clk_i);
    ev = sb.pop_front(); total++;
    if (obs !== ev) begin bad++; $display("FAIL clamp_hrs: got %s want %s", fmt(obs), fmt(ev)); end
    set_min_i = 6'd61; set_sec_i = 6'd63;
    sb.push_back(tup(23, 59, 59, 0, 0, 0, 0));
    repeat (3) @(negedge clk_i);
    ev = sb.pop_front(); total++;
    if (obs !== ev) begin bad++; $display("FAIL clamp_min_sec: got %s want %s", fmt(obs), fmt(ev)); end
    mode_i = 2'b00;
    sb.push_back(tup(11, 59, 59, 0, 1, 0, 0));
    repeat (2) @(negedge clk_i);
    ev = sb.pop_front(); total++;
    if (obs !== ev) begin bad++; $display("FAIL clk12_hr23: got %s want %s", fmt(obs), fmt(ev)); end
    set_en_i = 1'b0;
  endtask

  task automatic test_timer_expire();
    mode_i = 2'b10; set_hrs_i = 6'd0; set_min_i = 6'd0; set_sec_i = 6'd2;
    sb.push_back(tup(0, 0, 2, 0, 0, 0, 0));
    press(1'b0, 1'b1);
    ev = sb.pop_front(); total++;
    if (obs !== ev) begin bad++; $display("FAIL timer_clear_load: got %s want %s", fmt(obs), fmt(ev)); end
    wait_ms(1);
    sb.push_back(tup(0, 0, 2, 0, 0, 1, 0));
    press(1'b1, 1'b0);
    ev = sb.pop_front(); total++;
    if (obs !== ev) begin bad++; $display("FAIL timer_start: got %s want %s", fmt(obs), fmt(ev)); end
    sb.push_back(tup(0, 0, 0, 0, 0, 0, 1));
    wait_ms(2000);
    @(negedge clk_i);
    ev = sb.pop_front(); total++;
    if (obs !== ev) begin bad++; $display("FAIL timer_expire: got %s want %s", fmt(obs), fmt(ev)); end
    sb.push_back(tup(0, 0, 0, 0, 0, 0, 1));
    press(1'b1, 1'b0);
    ev = sb.pop_front(); total++;
    if (obs !== ev) begin bad++; $display("FAIL expired_start_ignored: got %s want %s", fmt(obs), fmt(ev)); end
    sb.push_back(tup(0, 0, 2, 0, 0, 0, 0));
    press(1'b0, 1'b1);
    ev = sb.pop_front(); total++;
    if (obs !== ev) begin bad++; $display("FAIL expired_clear: got %s want %s", fmt(obs), fmt(ev)); end
  endtask

  task automatic test_timer_pause();
    wait_ms(1);
    press(1'b1, 1'b0);
    wait_ms(500);
    sb.push_back(tup(0, 0, 1, 500, 0, 0, 0));
    press(1'b1, 1'b0);
    ev = sb.pop_front(); total++;
    if (obs !== ev) begin bad++; $display("FAIL timer_pause: got %s want %s", fmt(obs), fmt(ev)); end
    sb.push_back(tup(0, 0, 1, 500, 0, 0, 0));
    wait_ms(300);
    @(negedge clk_i);
    ev = sb.pop_front(); total++;
    if (obs !== ev) begin bad++; $display("FAIL timer_paused_hold: got %s want %s", fmt(obs), fmt(ev)); end
    sb.push_back(tup(0, 0, 1, 500, 0, 1, 0));
    press(1'b1, 1'b0);
    ev = sb.pop_front(); total++;
    if (obs !== ev) begin bad++; $display("FAIL timer_resume: got %s want %s", fmt(obs), fmt(ev)); end
    sb.push_back(tup(0, 0, 2, 0, 0, 0, 0));
    press(1'b0, 1'b1);
    ev = sb.pop_front(); total++;
    if (obs !== ev) begin bad++; $display("FAIL timer_run_clear: got %s want %s", fmt(obs), fmt(ev)); end
  endtask

  task automatic test_stopwatch();
    mode_i = 2'b11;
    sb.push_back(tup(0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge clk_i);
    ev = sb.pop_front(); total++;
    if (obs !== ev) begin bad++; $display("FAIL sw_idle: got %s want %s", fmt(obs), fmt(ev)); end
    wait_ms(1);
    press(1'b1, 1'b0);
    wait_ms(1234);
    sb.push_back(tup(0, 0, 1, 234, 0, 0, 0));
    press(1'b1, 1'b0);
    ev = sb.pop_front(); total++;
    if (obs !== ev) begin bad++; $display("FAIL sw_1234: got %s want %s", fmt(obs), fmt(ev)); end
    wait_ms(1);
    press(1'b1, 1'b0);
    wait_ms(1);
    sb.push_back(tup(0, 0, 1, 235, 0, 1, 0));
    press(1'b0, 1'b1);
    ev = sb.pop_front(); total++;
    if (obs !== ev) begin bad++; $display("FAIL sw_clear_in_run: got %s want %s", fmt(obs), fmt(ev)); end
    wait_ms(1);
    sb.push_back(tup(0, 0, 1, 236, 0, 0, 0));
    press(1'b1, 1'b0);
    ev = sb.pop_front(); total++;
    if (obs !== ev) begin bad++; $display("FAIL sw_pause2: got %s want %s", fmt(obs), fmt(ev)); end
    sb.push_back(tup(0, 0, 0, 0, 0, 0, 0));
    press(1'b0, 1'b1);
    ev = sb.pop_front(); total++;
    if (obs !== ev) begin bad++; $display("FAIL sw_clear_pause: got %s want %s", fmt(obs), fmt(ev)); end
  endtask

  task automatic test_back_to_back();
    mode_i = 2'b10;
    sb.push_back(tup(0, 0, 2, 0, 0, 0, 0));
    press(1'b1, 1'b1);
    ev = sb.pop_front(); total++;
    if (obs !== ev) begin bad++; $display("FAIL both_idle: got %s want %s", fmt(obs), fmt(ev)); end
    press(1'b1, 1'b0);
    total++;
    if (running_o !== 1'b1) begin bad++; $display("FAIL timer_rerun: got running=%0d want 1", running_o); end
    sb.push_back(tup(0, 0, 2, 0, 0, 0, 0));
    press(1'b1, 1'b1);
    ev = sb.pop_front(); total++;
    if (obs !== ev) begin bad++; $display("FAIL both_run: got %s want %s", fmt(obs), fmt(ev)); end
    mode_i = 2'b11;
    press(1'b1, 1'b0);
    total++;
    if (running_o !== 1'b1) begin bad++; $display("FAIL sw_rerun: got running=%0d want 1", running_o); end
    start_stop_i = 1'b1;
    @(negedge clk_i);
    #2 reset_i = 1'b1; start_stop_i = 1'b0;
    #1;
    sb.push_back(tup(0, 0, 0, 0, 0, 0, 0));
    ev = sb.pop_front(); total++;
    if (obs !== ev || ms_tick_o !== 1'b0) begin
      bad++; $display("FAIL async_reset: got %s tick=%0d want %s tick=0", fmt(obs), ms_tick_o, fmt(ev));
    end
    @(negedge clk_i);
    reset_i = 1'b0;
    sb.push_back(tup(0, 0, 0, 0, 0, 0, 0));
    repeat (6) @(negedge clk_i);
    ev = sb.pop_front(); total++;
    if (obs !== ev) begin bad++; $display("FAIL no_pending_press: got %s want %s", fmt(obs), fmt(ev)); end
  endtask

  initial begin
    reset_i = 1'b1; start_stop_i = 1'b0; clear_i = 1'b0; set_en_i = 1'b0; mode_i = 2'b00;
    set_hrs_i = '0; set_min_i = '0; set_sec_i = '0;
    test_reset();
    test_tick();
    test_wall_rollover();
    test_wall_set();
    test_timer_expire();
    test_timer_pause();
    test_stopwatch();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
